hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Stall/hazard controller for the in-order RV32I pipeline. It produces the i_stall and i_wait lines consumed by decode.
- Tracks in-flight destination registers with a per-register pending counter and stalls issue on RAW and WAW-overflow hazards.
- Holds the front end in a wait window after reset and after every control-flow redirect.
- Sits between decode (issue side) and execute/writeback (retire side).

Parameters:
- CW, 2, width of each per-register pending counter; a register saturates at 2**CW-1 outstanding writes.
- FLUSH_CYCLES, 2, number of cycles o_wait stays high after a redirect or reset (must be ≥1, <256).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_clk_en  in  1  global clock enable; all state updates are gated by it
- i_issue_valid  in  1  decode presents an instruction this cycle
- i_issue_rs1  in  5  source register 1
- i_issue_rs2  in  5  source register 2
- i_issue_use_rs1  in  1  instruction reads rs1
- i_issue_use_rs2  in  1  instruction reads rs2
- i_issue_rd  in  5  destination register
- i_issue_wr_rd  in  1  instruction writes rd
- i_wb_valid  in  1  one tracked write retires or is squashed this cycle
- i_wb_rd  in  5  register of that retiring/squashed write
- i_redirect  in  1  execute took a branch/jump/trap; front end must flush
- o_stall  out  1  combinational; issue blocked this cycle (to decode i_stall)
- o_wait  out  1  registered; flush/wait window active (to decode i_wait)
- o_busy  out  32  registered; bit n high when counter[n] != 0; bit 0 is always 0

Behaviour:
- Reset (i_rst high at a clock edge):
  - All counters are cleared to 0 and o_busy reads 32'h0.
  - o_wait = 1 and the wait counter is loaded with FLUSH_CYCLES.
  - Reset overrides any issue, writeback or redirect in the same cycle, including mid-flush.
- Hazard terms:
  - raw1 = use_rs1 && rs1 != 0 && busy[rs1]
  - raw2 = use_rs2 && rs2 != 0 && busy[rs2]
  - waw = wr_rd && rd != 0 && counter[rd] == max
- Stall:
  - o_stall = i_issue_valid && (raw1 || raw2 || waw || o_wait).
  - o_stall is purely combinational from inputs and current state; zero-cycle latency.
- Issue:
  - An issue is accepted when i_issue_valid && !o_stall && i_clk_en.
  - On an accepted issue with wr_rd && rd != 0, counter[rd] increments at the next edge.
- Writeback:
  - When i_wb_valid && i_wb_rd != 0 && i_clk_en, counter[wb_rd] decrements.
  - i_wb_valid is pulsed for every tracked write, whether it retires or is squashed.
- Same-register issue and writeback in one cycle: the counter is unchanged (+1 and -1 cancel).
- Writeback to a register whose counter is 0: ignored, counter stays 0. This is a protocol error; an assertion fires in simulation only.
- x0 is never tracked; it never causes a stall and never increments.
- Wait window:
  - i_redirect (with i_clk_en) reloads the wait counter to FLUSH_CYCLES and sets o_wait = 1 at the next edge.
  - While the counter is > 0 it decrements each enabled cycle; o_wait drops the cycle after the counter reaches 0.
  - A redirect arriving during an active window reloads the counter (window restarts).
  - Redirect does not clear the scoreboard; in-flight writes drain via i_wb_valid.
- An issue and a redirect in the same cycle: the issue is still accepted if o_stall was low, and its rd is tracked. Execute squashes that instruction and reports it on i_wb_valid.
- With i_clk_en low, all state holds; o_stall still reflects the current state.

Optional Feature:
- Macro: HAZARD_WB_BYPASS_EN.
- Defined: a RAW term is masked when i_wb_valid && i_wb_rd equals that source and counter[src] == 1. The writeback is forwarded in the same cycle, so no stall.
- Undefined: a RAW stall holds until the cycle after the counter reaches 0.

Test Plan:
- Reset release: i_rst for 1 cycle with FLUSH_CYCLES=2 → o_wait=1 for 2 cycles after reset, o_stall=1 for any valid issue during that window, o_busy=0.
- Issue addi x5 (wr_rd, rd=5), then add x6,x5,x1 next cycle → o_stall=1, o_busy[5]=1. Pulse wb rd=5 → o_stall=0 the following cycle without bypass, and the same cycle with HAZARD_WB_BYPASS_EN.
- Three issues writing x7 with no writeback (CW=2, max=3) → fourth write to x7 stalls (waw). One wb rd=7 → the fourth issue is accepted the next cycle.
- Issue writing x9 and wb rd=9 in the same cycle with counter[9]=1 → counter[9] stays 1, o_busy[9]=1.
- i_redirect at cycle 10, again at cycle 11 → o_wait high cycles 11–13, low at 14; the scoreboard is unchanged.
- Issue with rd=0 and rs1=0 repeatedly → never stalls (after the wait window), o_busy[0]=0. Wb to an idle register → counter stays 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue stall and front-end wait controller for the
// in-order RV32I pipeline. A saturating pending-write counter per register
// detects RAW hazards, and WAW hazards when a register's counter is full.
// A wait window holds the front end for FLUSH_CYCLES cycles after reset or
// after a redirect.
// Optional feature: define HAZARD_WB_BYPASS_EN so that a writeback retiring
// the last outstanding write to a source register masks that RAW term in the
// same cycle. The writeback value is forwarded, so the issue does not stall.
module hazard_scoreboard #(
    parameter int CW           = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_en,
    input  logic        i_issue_valid,
    input  logic [4:0]  i_issue_rs1,
    input  logic [4:0]  i_issue_rs2,
    input  logic        i_issue_use_rs1,
    input  logic        i_issue_use_rs2,
    input  logic [4:0]  i_issue_rd,
    input  logic        i_issue_wr_rd,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    input  logic        i_redirect,
    output logic        o_stall,
    output logic        o_wait,
    output logic [31:0] o_busy
);

    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [7:0]    FLUSH_LOAD = 8'(FLUSH_CYCLES);

    logic [CW-1:0] cnt_q [32];
    logic [CW-1:0] cnt_d [32];
    logic [31:0]   busy_q, busy_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic          wait_q, wait_d;

    logic          raw1, raw2, waw, byp1, byp2, accept;
    logic [31:0]   inc_vec, dec_vec;

    // Hazard detection and stall: combinational from inputs and current state.
    always_comb begin
        raw1 = i_issue_use_rs1 && (i_issue_rs1 != 5'd0) && busy_q[i_issue_rs1];
        raw2 = i_issue_use_rs2 && (i_issue_rs2 != 5'd0) && busy_q[i_issue_rs2];
        waw  = i_issue_wr_rd && (i_issue_rd != 5'd0) && (cnt_q[i_issue_rd] == CNT_MAX);
`ifdef HAZARD_WB_BYPASS_EN
        // The writeback is retiring the only outstanding write to the source.
        byp1 = i_wb_valid && (i_wb_rd == i_issue_rs1) && (cnt_q[i_issue_rs1] == CNT_ONE);
        byp2 = i_wb_valid && (i_wb_rd == i_issue_rs2) && (cnt_q[i_issue_rs2] == CNT_ONE);
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
        o_stall = i_issue_valid && ((raw1 && !byp1) || (raw2 && !byp2) || waw || wait_q);
        accept  = i_issue_valid && !o_stall && i_clk_en;
    end

    // Per-register counter update: +1 on an accepted write issue, -1 on
    // writeback. Both at once cancel. x0 is never tracked, and a writeback
    // to an idle register is dropped so the counter cannot wrap.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        busy_d  = '0;
        for (int n = 0; n < 32; n++) begin
            cnt_d[n]   = cnt_q[n];
            inc_vec[n] = accept && i_issue_wr_rd && (i_issue_rd == 5'(n)) && (n != 0);
            dec_vec[n] = i_clk_en && i_wb_valid && (i_wb_rd == 5'(n)) && (n != 0)
                         && (cnt_q[n] != '0);
            if (inc_vec[n] && !dec_vec[n]) begin
                cnt_d[n] = cnt_q[n] + CNT_ONE;
            end else if (dec_vec[n] && !inc_vec[n]) begin
                cnt_d[n] = cnt_q[n] - CNT_ONE;
            end
            busy_d[n] = (cnt_d[n] != '0);
        end
    end

    // Wait window: a redirect reloads the counter. Otherwise the counter runs
    // down. o_wait is high while the counter is non-zero.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        wait_d     = wait_q;
        if (i_clk_en) begin
            if (i_redirect) begin
                wait_cnt_d = FLUSH_LOAD;
            end else if (wait_cnt_q != 8'd0) begin
                wait_cnt_d = wait_cnt_q - 8'd1;
            end
            wait_d = (wait_cnt_d != 8'd0);
        end
    end

    // State registers. Reset overrides every other input.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int n = 0; n < 32; n++) begin
                cnt_q[n] <= '0;
            end
            busy_q     <= '0;
            wait_cnt_q <= FLUSH_LOAD;
            wait_q     <= 1'b1;
        end else begin
            for (int n = 0; n < 32; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
            busy_q     <= busy_d;
            wait_cnt_q <= wait_cnt_d;
            wait_q     <= wait_d;
        end
    end

    assign o_wait = wait_q;
    assign o_busy = busy_q;

`ifndef SYNTHESIS
    // A writeback to a register with no outstanding write is a protocol error.
    wb_idle_chk: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_clk_en && i_wb_valid && (i_wb_rd != 5'd0) && (cnt_q[i_wb_rd] == '0)));
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard. It runs directed scenarios and then a
// randomized phase. Both are checked against a behavioural model that holds
// pending-write counts as plain integers.
module tb_hazard_scoreboard;

    localparam int CW    = 2;
    localparam int FLUSH = 2;
    localparam int MAXC  = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst, clk_en, valid, use1, use2, wr, wbv, redirect;
    logic [4:0]  rs1, rs2, rd, wbrd;
    logic        o_stall, o_wait;
    logic [31:0] o_busy;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    int pend [32];
    int wait_left;

    hazard_scoreboard #(.CW(CW), .FLUSH_CYCLES(FLUSH)) dut (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
        .i_issue_valid(valid), .i_issue_rs1(rs1), .i_issue_rs2(rs2),
        .i_issue_use_rs1(use1), .i_issue_use_rs2(use2),
        .i_issue_rd(rd), .i_issue_wr_rd(wr),
        .i_wb_valid(wbv), .i_wb_rd(wbrd), .i_redirect(redirect),
        .o_stall(o_stall), .o_wait(o_wait), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    function automatic bit src_hazard(input logic u, input logic [4:0] r);
        bit h;
        h = u && (r != 0) && (pend[r] > 0);
`ifdef HAZARD_WB_BYPASS_EN
        if (wbv && (wbrd == r) && (pend[r] == 1)) h = 0;
`endif
        return h;
    endfunction

    function automatic bit model_stall();
        return valid && ((wait_left > 0) || src_hazard(use1, rs1) || src_hazard(use2, rs2)
                         || (wr && (rd != 0) && (pend[rd] == MAXC)));
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        for (int n = 1; n < 32; n++) b[n] = (pend[n] > 0);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Compare the outputs with the model at the falling edge, then print one
    // line for this transaction.
    task automatic sample(input string tag);
        @(negedge clk);
        chk({tag, ".stall"}, 32'(o_stall), 32'(model_stall()));
        chk({tag, ".wait"},  32'(o_wait),  32'(wait_left > 0));
        chk({tag, ".busy"},  o_busy,       model_busy());
        $display("[TB] %s v=%0b rs1=%0d rs2=%0d rd=%0d wr=%0b wb=%0b/%0d redir=%0b en=%0b -> stall=%0b wait=%0b busy=%h",
                 tag, valid, rs1, rs2, rd, wr, wbv, wbrd, redirect, clk_en, o_stall, o_wait, o_busy);
    endtask

    // Advance one clock edge and apply the model's update rules.
    task automatic tick();
        bit st;
        @(posedge clk);
        if (rst) begin
            for (int n = 0; n < 32; n++) pend[n] = 0;
            wait_left = FLUSH;
        end else if (clk_en) begin
            st = model_stall();
            if (valid && !st && wr && rd != 0) pend[rd]++;
            if (wbv && wbrd != 0 && pend[wbrd] > 0) pend[wbrd]--;
            if (redirect) wait_left = FLUSH;
            else if (wait_left > 0) wait_left--;
        end
        #1;
    endtask

    task automatic set_issue(input logic v, input logic u1, input logic [4:0] r1,
                             input logic u2, input logic [4:0] r2,
                             input logic w, input logic [4:0] d);
        valid = v; use1 = u1; rs1 = r1; use2 = u2; rs2 = r2; wr = w; rd = d;
    endtask

    initial begin
        int cand [$];
        rst = 1; clk_en = 1; valid = 0; use1 = 0; use2 = 0; wr = 0; wbv = 0; redirect = 0;
        rs1 = 0; rs2 = 0; rd = 0; wbrd = 0;
        for (int n = 0; n < 32; n++) pend[n] = 0;
        wait_left = FLUSH;

        // Reset, then the wait window after release.
        tick(); tick();
        rst = 0;
        set_issue(1, 0, 0, 0, 0, 0, 0);
        sample("rst_w1");
        chk("rst_w1.wait_const", 32'(o_wait), 32'd1);
        chk("rst_w1.stall_const", 32'(o_stall), 32'd1);
        chk("rst_w1.busy_const", o_busy, 32'h0);
        tick();
        sample("rst_w2");
        chk("rst_w2.wait_const", 32'(o_wait), 32'd1);
        tick();
        sample("rst_w3");
        chk("rst_w3.wait_const", 32'(o_wait), 32'd0);
        tick();

        // RAW on x5, released by a writeback.
        set_issue(1, 0, 0, 0, 0, 1, 5'd5);
        sample("addi_x5"); tick();
        set_issue(1, 1, 5'd5, 1, 5'd1, 1, 5'd6);
        sample("add_raw");
        chk("add_raw.stall_const", 32'(o_stall), 32'd1);
        chk("add_raw.busy5", 32'(o_busy[5]), 32'd1);
        tick();
        wbv = 1; wbrd = 5'd5;
        sample("add_wb");
`ifdef HAZARD_WB_BYPASS_EN
        chk("add_wb.stall_const", 32'(o_stall), 32'd0);
`else
        chk("add_wb.stall_const", 32'(o_stall), 32'd1);
`endif
        tick();
        wbv = 0;
        sample("add_after");
        chk("add_after.stall_const", 32'(o_stall), 32'd0);
        tick();

        // WAW saturation on x7.
        set_issue(1, 0, 0, 0, 0, 1, 5'd7);
        for (int k = 0; k < 3; k++) begin
            sample("x7_fill"); tick();
        end
        sample("x7_waw");
        chk("x7_waw.stall_const", 32'(o_stall), 32'd1);
        tick();
        wbv = 1; wbrd = 5'd7;
        sample("x7_wb"); tick();
        wbv = 0;
        sample("x7_accept");
        chk("x7_accept.stall_const", 32'(o_stall), 32'd0);
        tick();

        // Same-register issue and writeback on x9 cancel.
        set_issue(1, 0, 0, 0, 0, 1, 5'd9);
        sample("x9_issue"); tick();
        wbv = 1; wbrd = 5'd9;
        sample("x9_both"); tick();
        wbv = 0; valid = 0;
        sample("x9_after");
        chk("x9_after.busy9", 32'(o_busy[9]), 32'd1);
        tick();

        // Back-to-back redirects restart the window.
        redirect = 1;
        tick();
        sample("redir_c11");
        chk("redir_c11.wait_const", 32'(o_wait), 32'd1);
        tick();
        redirect = 0;
        sample("redir_c12"); tick();
        sample("redir_c13");
        chk("redir_c13.wait_const", 32'(o_wait), 32'd1);
        tick();
        sample("redir_c14");
        chk("redir_c14.wait_const", 32'(o_wait), 32'd0);
        tick();

        // x0 is never tracked.
        set_issue(1, 1, 5'd0, 0, 0, 1, 5'd0);
        for (int k = 0; k < 4; k++) begin
            sample("x0_issue");
            chk("x0_issue.stall_const", 32'(o_stall), 32'd0);
            chk("x0_issue.busy0", 32'(o_busy[0]), 32'd0);
            tick();
        end

        // With the clock enable low, all state holds.
        clk_en = 0; redirect = 1;
        set_issue(1, 0, 0, 0, 0, 1, 5'd10);
        tick();
        clk_en = 1; redirect = 0; valid = 0;
        sample("en_low");
        chk("en_low.busy10", 32'(o_busy[10]), 32'd0);
        chk("en_low.wait_const", 32'(o_wait), 32'd0);
        tick();

        // Randomized traffic. Writebacks only target registers with an
        // outstanding write.
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 99) == 0);
            clk_en   = ($urandom_range(0, 7) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            set_issue($urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                      $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                      $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)));
            cand.delete();
            for (int n = 1; n < 32; n++) if (pend[n] > 0) cand.push_back(n);
            wbv = 0; wbrd = 5'($urandom_range(0, 7));
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                wbv  = 1;
                wbrd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
            end
            sample("rand");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
